// File: rtl/pico_pkg.sv
// Shared types and constants for the picoMIPS I/O sequencer.
`timescale 1ns/1ps
package pico_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        CAPTURE   = 2'd2
    } ioseq_state_t;

    typedef struct packed {
        logic              tag;
        logic [DATA_W-1:0] value;
    } operand_t;

endpackage

// File: rtl/pico_io_sequencer_sync_edge.sv
// Synchroniser, optional debounce (IOSEQ_DEBOUNCE_EN) and rising-edge detector for readyin.
`timescale 1ns/1ps
module sync_edge #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic nreset,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic r_s1;
    logic r_s2;
    logic r_prev;
    logic w_level;

    // Two-stage synchroniser; resets high so a strobe held through reset is never seen as a new edge.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= async_in;
            r_s2 <= r_s1;
        end
    end

`ifdef IOSEQ_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_deb;

    // Debounced level changes only after the synced level has differed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cnt <= '0;
            r_deb <= 1'b1;
        end else if (r_s2 != r_deb) begin
            if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_cnt <= '0;
                r_deb <= r_s2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_level = r_deb;
`else
    assign w_level = r_s2;
`endif

    // Previous level for edge detection.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= w_level;
        end
    end

    assign level = w_level;
    assign rise  = w_level & ~r_prev;

endmodule

// File: rtl/pico_io_sequencer.sv
// Switch/LED I/O sequencer for picoMIPS: operand capture FIFO, input stall and output latch.
// Optional debounce on readyin is compiled in with IOSEQ_DEBOUNCE_EN.
`timescale 1ns/1ps
module pico_io_sequencer
    import pico_pkg::*;
#(
    parameter int DEPTH           = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              readyin,
    input  logic [DATA_W-1:0] sw,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_tag,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] outport,
    output logic              overrun
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              w_level;
    logic              w_rise;
    logic [DATA_W-1:0] r_sw_s1;
    logic [DATA_W-1:0] r_sw_s2;

    ioseq_state_t      r_state;
    ioseq_state_t      w_state_next;
    logic              r_tag;

    operand_t          r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;

    sync_edge #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync_edge (
        .clk      (clk),
        .nreset   (nreset),
        .async_in (readyin),
        .level    (w_level),
        .rise     (w_rise)
    );

    // Operand bus synchroniser; sw is stable while readyin is high so no edge logic is needed.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= sw;
            r_sw_s2 <= r_sw_s1;
        end
    end

    // Capture FSM state register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= WAIT_LOW;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture FSM next state: arm on a low level, fire on a rising edge, capture for one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WAIT_LOW: begin
                if (!w_level) begin
                    w_state_next = WAIT_HIGH;
                end else begin
                    w_state_next = WAIT_LOW;
                end
            end
            WAIT_HIGH: begin
                if (w_rise) begin
                    w_state_next = CAPTURE;
                end else begin
                    w_state_next = WAIT_HIGH;
                end
            end
            CAPTURE: begin
                w_state_next = WAIT_LOW;
            end
            default: begin
                w_state_next = WAIT_LOW;
            end
        endcase
    end

    assign w_empty   = (r_count == CNT_W'(0));
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_push    = (r_state == CAPTURE) && !w_full;
    assign w_pop     = cpu_rd && !w_empty;
    assign cpu_stall = cpu_rd && w_empty;

    // FIFO pointers, occupancy, x/y tag and sticky overrun flag.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_tag   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : r_wptr + PTR_W'(1);
                r_tag  <= ~r_tag;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if ((r_state == CAPTURE) && w_full) begin
                overrun <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care once flushed, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{tag: r_tag, value: r_sw_s2};
        end
    end

    // Head of FIFO is presented combinationally so a ready operand costs no extra cycle.
    always_comb begin
        cpu_data = '0;
        cpu_tag  = 1'b0;
        if (!w_empty) begin
            cpu_data = r_mem[r_rptr].value;
            cpu_tag  = r_mem[r_rptr].tag;
        end else begin
            cpu_data = '0;
            cpu_tag  = 1'b0;
        end
    end

    // LED output register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            outport <= '0;
        end else if (cpu_wr) begin
            outport <= cpu_wdata;
        end
    end

endmodule

// File: doc/pico_io_sequencer.md
# pico_io_sequencer

Input/output sequencer between the picoMIPS core and the board switches and LEDs. It synchronises the asynchronous `readyin` strobe, captures one 8-bit operand from `sw` per strobe into a 2-entry buffer, and stalls the core on an input instruction until an operand is available. Each operand is tagged as the x or y half of a coordinate pair. On a core output instruction it latches the result onto `outport`.

## Interface
- `DEPTH`, 2: operand buffer entries; must be a power of two.
- `DEBOUNCE_CYCLES`, 4: stable cycles required on `readyin`; used only with the debounce feature compiled in.
- `clk` in 1: system clock.
- `nreset` in 1: asynchronous, active-low reset.
- `readyin` in 1: asynchronous operand strobe (SW8).
- `sw` in 8: asynchronous operand value; stable while `readyin` is high.
- `cpu_rd` in 1: core executing an input instruction; held high while `cpu_stall` is high.
- `cpu_wr` in 1: single-cycle output-instruction strobe.
- `cpu_wdata` in 8: result to display.
- `cpu_data` out 8: operand at the buffer head.
- `cpu_tag` out 1: tag of the head entry; 0 = x, 1 = y.
- `cpu_stall` out 1: core must hold its PC.
- `outport` out 8: LED register.
- `overrun` out 1: sticky; an operand was dropped.

## Operation
- `readyin` and `sw` pass through 2-FF synchronisers; a third register on `readyin` provides edge detection.
- Capture FSM:
  - WAIT_LOW: reset state; go to WAIT_HIGH when synced `readyin`=0. A `readyin` already high out of reset is never captured.
  - WAIT_HIGH: on a synced rising edge, go to CAPTURE.
  - CAPTURE: one cycle; write {tag, synced `sw`} to the buffer, toggle tag, go to WAIT_LOW.
- Tag register resets to 0 and toggles on every successful write. A dropped operand does not toggle it.
- Buffer is a circular FIFO with DEPTH entries and wrap-around pointers.
- Full at CAPTURE: no write, `overrun`←1. `overrun` clears only on reset.
- Read path:
  - `cpu_rd`=1 and buffer non-empty: `cpu_stall`=0; `cpu_data`/`cpu_tag` come combinationally from the head; pop on the clock edge.
  - `cpu_rd`=1 and buffer empty: `cpu_stall`=1.
  - `cpu_rd`=0: `cpu_stall`=0.
- Write and pop in the same cycle:
  - Both happen if non-empty; count is unchanged.
  - If empty, only the write happens; the pop occurs next cycle.
- Empty-buffer read: `cpu_data` is 8'h00 and `cpu_tag` is 0.
- `cpu_wr`=1: `outport`←`cpu_wdata` at the next edge; held until the next `cpu_wr`.
- Reset mid-operation: buffer flushed, FSM→WAIT_LOW, tag=0. A partially entered pair is discarded.

## Timing
- Reset values: `outport`=8'h00, `overrun`=0, `cpu_data`=8'h00, `cpu_tag`=0.
- `cpu_stall` reset value is 0; while reset is released it follows `cpu_rd` (buffer empty).
- Capture latency (no debounce): `readyin` is first sampled high at edge k; the FSM is in CAPTURE during the cycle after edge k+2; the write occurs at edge k+3.
- Stall release: with `cpu_rd` held, `cpu_stall` falls in the cycle after the write edge, and the pop occurs at the following edge.
- Minimum pulse: `readyin` high ≥2 cycles and low ≥2 cycles between operands; shorter pulses may be missed.
- `outport` updates exactly 1 cycle after `cpu_wr`.

## Configuration
- `IOSEQ_DEBOUNCE_EN` defined:
  - A counter after the synchroniser requires the synced `readyin` to stay at a new level for DEBOUNCE_CYCLES consecutive cycles before the debounced level changes.
  - The FSM uses the debounced level.
  - Capture latency increases by DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES produces no capture.
- `IOSEQ_DEBOUNCE_EN` undefined: the synchronised level is used directly, there is no counter, and DEBOUNCE_CYCLES is ignored.

## Structure
- `pico_pkg` holds:
  - capture FSM state enum `ioseq_state_t` {WAIT_LOW, WAIT_HIGH, CAPTURE};
  - packed struct `operand_t` {logic tag; logic [7:0] value};
  - constant `DATA_W`=8.
- Sub-module `sync_edge`: 2-FF synchroniser, optional debounce counter (under the macro), and edge register. It outputs `level` and `rise`.
- FSM, FIFO and output register stay in `pico_io_sequencer`.

## Test plan
- Reset with `readyin`=1, release, hold `readyin` 10 cycles: no capture; buffer empty; `cpu_rd`=1 gives `cpu_stall`=1.
- `readyin` pulse with `sw`=8'h05, then pulse with `sw`=8'hFB, then `cpu_rd` for 2 reads: `cpu_data`=8'h05/tag 0, then 8'hFB/tag 1; `cpu_stall`=0 for both.
- `cpu_rd` held with buffer empty, then `readyin` rises with `sw`=8'h05 (at sampling edge k): `cpu_stall`=1 until the cycle after edge k+3, then `cpu_data`=8'h05 and the pop occurs at edge k+4.
- Three pulses (8'h01, 8'h02, 8'h03) with no reads: `overrun`=1; reads return 8'h01 tag 0, then 8'h02 tag 1; the next pulse is tagged 0.
- `cpu_wr` with `cpu_wdata`=8'h3C: `outport`=8'h3C one cycle later and held; assert `nreset` mid-pair, then `outport`=8'h00, `overrun`=0, and the next operand is tagged 0.
- With `IOSEQ_DEBOUNCE_EN`: a 2-cycle `readyin` glitch gives no capture; a 10-cycle pulse with `sw`=8'h7F is captured DEBOUNCE_CYCLES later than without the macro.
